// File: rtl/muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master side issues operations and the slave side (the unit) returns results.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            go;
    logic            ack;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output go, ack, kill, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  go, ack, kill, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV-style multiply/divide: radix-2^MUL_BITS shift-add multiply and
// restoring divide (DIV_BITS quotient bits per cycle) on operand magnitudes.
//
// state  | meaning
// IDLE   | waiting for go
// MUL    | multiply iterations, MUL_BITS multiplier bits per cycle
// DIV    | divide iterations, DIV_BITS quotient bits per cycle
// FIX    | apply sign correction, load result
// DONE   | result valid, held until ack
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 1
) (
    input  logic    clk_core,
    input  logic    reset_n,
    muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN / MUL_BITS);
    localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(XLEN / DIV_BITS);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_res;
    logic              neg_rem;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   res_q;

    logic              start;
    logic              is_div;
    logic              byp_zero;
    logic              byp_ovf;
    logic              bypass;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    always_comb begin
        start = 1'b0;
        if (!bus.kill)
            start = bus.go && ((state == S_IDLE) || ((state == S_DONE) && bus.ack));
        is_div   = bus.op[2];
        byp_zero = is_div && (bus.b == '0);
        byp_ovf  = is_div && !bus.op[0] && (bus.a == MOST_NEG) && (bus.b == '1);
        bypass   = byp_zero || byp_ovf;
        // MUL low half is sign-agnostic, so it runs unsigned
        a_signed = bus.op[2] ? !bus.op[0] : ((bus.op == 3'd1) || (bus.op == 3'd2));
        b_signed = bus.op[2] ? !bus.op[0] : (bus.op == 3'd1);
        a_neg    = a_signed && bus.a[XLEN-1];
        b_neg    = b_signed && bus.b[XLEN-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = bypass ? S_DONE : (is_div ? S_DIV : S_MUL);
            end
            S_MUL, S_DIV: begin
                if (cnt == CNT_W'(1))
                    state_nxt = S_FIX;
            end
            S_FIX: state_nxt = S_DONE;
            S_DONE: begin
                if (start)
                    state_nxt = bypass ? S_DONE : (is_div ? S_DIV : S_MUL);
                else if (bus.ack)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.kill)
            state_nxt = S_IDLE;
    end

    assign bus.busy   = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign bus.done   = (state == S_DONE);
    assign bus.result = res_q;

    logic [XLEN+MUL_BITS-1:0] pp;
    logic [XLEN+MUL_BITS-1:0] hi_sum;
    logic [2*XLEN-1:0]        mul_nxt;
    logic [2*XLEN-1:0]        div_nxt;
    logic [XLEN:0]            rem_sh;
    logic [XLEN:0]            diff;

    always_comb begin
        pp      = {{MUL_BITS{1'b0}}, opnd} * {{XLEN{1'b0}}, acc[MUL_BITS-1:0]};
        hi_sum  = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]} + pp;
        mul_nxt = {hi_sum, acc[XLEN-1:MUL_BITS]};

        // {remainder, quotient} shift left one restoring step at a time
        div_nxt = acc;
        rem_sh  = '0;
        diff    = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            rem_sh = {div_nxt[2*XLEN-1:XLEN], div_nxt[XLEN-1]};
            diff   = rem_sh - {1'b0, opnd};
            if (!diff[XLEN])
                div_nxt = {diff[XLEN-1:0], div_nxt[XLEN-2:0], 1'b1};
            else
                div_nxt = {rem_sh[XLEN-1:0], div_nxt[XLEN-2:0], 1'b0};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem_f;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        prod  = neg_res ? -acc : acc;
        quo   = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_f = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:             fix_val = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_val = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_val = quo;
            default:          fix_val = rem_f;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            res_q   <= '0;
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (start) begin
            op_q    <= bus.op;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd    <= is_div ? b_mag : a_mag;
            cnt     <= is_div ? DIV_ITERS : MUL_ITERS;
            if (byp_zero)
                res_q <= bus.op[1] ? bus.a : '1;
            else if (byp_ovf)
                res_q <= bus.op[1] ? '0 : bus.a;
        end else begin
            case (state)
                S_MUL: begin
                    acc <= mul_nxt;
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                end
                S_DIV: begin
                    acc <= div_nxt;
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                end
                S_FIX:   res_q <= fix_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results/latency, plus
// hand sequences for kill, reset, handshake and back-to-back starts.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(1)) dut (
        .clk_core (clk),
        .reset_n  (rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issues go in the current cycle (cycle 0) and counts cycles to done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit do_ack, output logic [31:0] res, output int lat,
                          output bit busy_ok);
        bus.go = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        tick();
        bus.go  = 1'b0;
        bus.ack = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        res     = 'x;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                lat = c;
                res = bus.result;
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            tick();
        end
        if (do_ack) begin
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
        end
    endtask

    logic [31:0] res;
    int          lat;
    bit          bok;

    initial begin
        vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 10});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10});
        vecs.push_back('{3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 10});
        vecs.push_back('{3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 10});
        vecs.push_back('{3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 10});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        34});
        vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         34});
        vecs.push_back('{3'd4, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'h0000_0003, 34});
        vecs.push_back('{3'd6, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 34});
        vecs.push_back('{3'd4, 32'h0000_0014, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'h0000_0014, 32'hFFFF_FFFA, 32'h0000_0002, 34});
        vecs.push_back('{3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34});
        vecs.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd6, 32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

        rst_n    = 1'b0;
        bus.go   = 1'b0;
        bus.ack  = 1'b0;
        bus.kill = 1'b0;
        bus.op   = 3'd0;
        bus.a    = '0;
        bus.b    = '0;
        repeat (3) tick();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, res, lat, bok);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
        end

        // kill at cycle 5 of a DIV, with a coincident go that must be dropped
        bus.go = 1'b1; bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.go = 1'b0;
        repeat (4) tick();
        bus.kill = 1'b1; bus.go = 1'b1; bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd2;
        tick();
        bus.kill = 1'b0; bus.go = 1'b0;
        chk("kill_busy_c6", 32'(bus.busy), 32'd0);
        chk("kill_done_c6", 32'(bus.done), 32'd0);
        tick();
        chk("kill_go_dropped", 32'(bus.busy), 32'd0);
        run_op(3'd0, 32'd3, 32'd3, 1'b1, res, lat, bok);
        chk("after_kill_result", res, 32'd9);
        chk("after_kill_latency", 32'(lat), 32'd10);

        // reset mid-MUL, then go on the first edge out of reset
        bus.go = 1'b1; bus.op = 3'd0; bus.a = 32'd11; bus.b = 32'd13;
        tick();
        bus.go = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0; bus.kill = 1'b1; bus.ack = 1'b1;
        tick();
        bus.kill = 1'b0; bus.ack = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        rst_n = 1'b1;
        run_op(3'd0, 32'd11, 32'd13, 1'b1, res, lat, bok);
        chk("post_rst_result", res, 32'd143);
        chk("post_rst_latency", 32'(lat), 32'd10);

        // go and ack while busy are ignored; operands stay latched
        bus.go = 1'b1; bus.op = 3'd0; bus.a = 32'd6; bus.b = 32'd7;
        tick();
        bus.go = 1'b0;
        tick();
        bus.go = 1'b1; bus.ack = 1'b1; bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd100;
        tick();
        bus.go = 1'b0; bus.ack = 1'b0;
        lat = -1;
        for (int c = 3; c <= 40; c++) begin
            if (bus.done) begin lat = c; break; end
            tick();
        end
        chk("go_busy_result", bus.result, 32'd42);
        chk("go_busy_latency", 32'(lat), 32'd10);

        // hold in DONE without ack
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold%0d_done", k), 32'(bus.done), 32'd1);
            chk($sformatf("hold%0d_result", k), bus.result, 32'd42);
        end

        // back-to-back start from DONE
        bus.ack = 1'b1;
        bus.go = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
        tick();
        bus.go = 1'b0; bus.ack = 1'b0;
        chk("b2b_busy_c1", 32'(bus.busy), 32'd1);
        chk("b2b_done_c1", 32'(bus.done), 32'd0);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin lat = c; break; end
            tick();
        end
        chk("b2b_result", bus.result, 32'd25);
        chk("b2b_latency", 32'(lat), 32'd10);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("ack_to_idle_done", 32'(bus.done), 32'd0);
        chk("ack_to_idle_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
